// File: rtl/prim_fifo_sync_wm.sv
// Single-clock FIFO of arbitrary depth with synchronous clear, occupancy watermarks
// and sticky peak-occupancy tracking. Optional bypass: PRIM_FIFO_SYNC_WM_PASSTHRU_EN.
module prim_fifo_sync_wm #(
  parameter int unsigned Width             = 16,
  parameter int unsigned Depth             = 4,
  parameter bit          OutputZeroIfEmpty = 1'b0,
  localparam int unsigned DepthW           = $clog2(Depth + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              wvalid_i,
  output logic              wready_o,
  input  logic [Width-1:0]  wdata_i,
  output logic              rvalid_o,
  input  logic              rready_i,
  output logic [Width-1:0]  rdata_o,
  input  logic [DepthW-1:0] af_thresh_i,
  input  logic [DepthW-1:0] ae_thresh_i,
  output logic [DepthW-1:0] depth_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic [DepthW-1:0] max_depth_o
);

  localparam int unsigned       PtrW      = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [DepthW-1:0] DepthFull = DepthW'(Depth);
  localparam logic [PtrW-1:0]   PtrLast   = PtrW'(Depth - 1);

  logic [Width-1:0]  storage [Depth];
  logic [PtrW-1:0]   wptr, rptr;
  logic [DepthW-1:0] cnt, cnt_next;
  logic [DepthW-1:0] max_q, max_next;
  logic              empty, full;
  logic              wr_fire, rd_fire, wr_en, rd_en, bypass;
  logic [Width-1:0]  rdata_raw;

  // Explicit wrap compare keeps non-power-of-two depths correct; Depth=1 pins to 0.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  assign empty    = (cnt == '0);
  assign full     = (cnt == DepthFull);
  assign wready_o = ~full & ~clr_i;

`ifdef PRIM_FIFO_SYNC_WM_PASSTHRU_EN
  // An empty FIFO presents the incoming word directly; if it is taken the same
  // cycle it never touches storage.
  assign bypass    = empty & ~clr_i & wvalid_i & rready_i;
  assign rvalid_o  = (~empty | wvalid_i) & ~clr_i;
  assign rdata_raw = empty ? wdata_i : storage[rptr];
`else
  assign bypass    = 1'b0;
  assign rvalid_o  = ~empty & ~clr_i;
  assign rdata_raw = storage[rptr];
`endif

  assign wr_fire = wvalid_i & wready_o;
  assign rd_fire = rvalid_o & rready_i;
  assign wr_en   = wr_fire & ~bypass;
  assign rd_en   = rd_fire & ~bypass;

  assign rdata_o        = (OutputZeroIfEmpty && !rvalid_o) ? '0 : rdata_raw;
  assign depth_o        = cnt;
  assign max_depth_o    = max_q;
  assign almost_full_o  = (cnt >= af_thresh_i);
  assign almost_empty_o = (cnt <= ae_thresh_i);

  always_comb begin
    cnt_next = cnt;
    max_next = max_q;
    if (clr_i) begin
      cnt_next = '0;
      max_next = '0;
    end else begin
      if (wr_en && !rd_en) begin
        cnt_next = cnt + DepthW'(1);
      end else if (rd_en && !wr_en) begin
        cnt_next = cnt - DepthW'(1);
      end
      max_next = (cnt_next > max_q) ? cnt_next : max_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      cnt   <= '0;
      max_q <= '0;
    end else begin
      cnt   <= cnt_next;
      max_q <= max_next;
      if (clr_i) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_en) wptr <= ptr_inc(wptr);
        if (rd_en) rptr <= ptr_inc(rptr);
      end
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) storage[wptr] <= wdata_i;
  end

  cnt_in_range_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cnt <= DepthFull);
  max_covers_cnt_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    max_q >= cnt);
  no_read_empty_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(rd_en && empty));
  no_write_full_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(wr_fire && full));
  rvalid_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rvalid_o && !rready_i) |=> (rvalid_o || clr_i));

endmodule
